uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx_param.sv | 143 ++++++++++++++
 tb/tb_uart_rx_param.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART receiver: FSM encoding,
// parity-mode constants and the bit-period computation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_BREAK = 3'd5
  } state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Clock cycles per line bit (integer division).
  function automatic int unsigned bit_cnt_f(input int unsigned clk_freq,
                                            input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: mid-bit sampling, optional parity, 1 or 2 stop
// bits, one-cycle rx_valid pulse with qualified parity/frame error flags.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned BIT_CNT = bit_cnt_f(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W   = $clog2(BIT_CNT);
  localparam int unsigned IDX_W   = $clog2(DATA_BITS + 1);
  localparam int unsigned MID     = BIT_CNT / 2 - 1;
  localparam int unsigned LAST    = BIT_CNT - 1;

  logic                 rx_s;
  logic                 rx_q;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 perr_q;
  logic                 ferr_q;

  logic fall_c, mid_c, wrap_c, last_stop_c, par_exp_c;
  logic start_c, shift_c, par_smp_c, stop_smp_c, stop_adv_c, done_c;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign fall_c      = rx_q & ~rx_s;
  assign mid_c       = (cnt_q == CNT_W'(MID));
  assign wrap_c      = (cnt_q == CNT_W'(LAST));
  assign last_stop_c = (STOP_BITS == 1) || stop_idx_q;
  assign par_exp_c   = (PARITY == PAR_ODD) ? ~(^shreg_q) : (^shreg_q);

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (fall_c) state_d = ST_START;
      ST_START: begin
        if (mid_c && rx_s) state_d = ST_IDLE;
        else if (wrap_c)   state_d = ST_DATA;
      end
      ST_DATA:  if (wrap_c && (bit_idx_q == IDX_W'(DATA_BITS)))
                  state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
      ST_PAR:   if (wrap_c) state_d = ST_STOP;
      // Leave at mid-stop so a following start edge half a bit later is caught.
      ST_STOP:  if (mid_c && last_stop_c)
                  state_d = (ferr_q || !rx_s) ? ST_BREAK : ST_IDLE;
      ST_BREAK: if (rx_s) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Per-state datapath strobes
  always_comb begin
    start_c    = 1'b0;
    shift_c    = 1'b0;
    par_smp_c  = 1'b0;
    stop_smp_c = 1'b0;
    stop_adv_c = 1'b0;
    done_c     = 1'b0;
    unique case (state_q)
      ST_IDLE: start_c   = fall_c;
      ST_DATA: shift_c   = mid_c;
      ST_PAR:  par_smp_c = mid_c;
      ST_STOP: begin
        stop_smp_c = mid_c && !last_stop_c;
        stop_adv_c = wrap_c;
        done_c     = mid_c && last_stop_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_q       <= 1'b1;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_q       <= rx_s;
      busy       <= (state_d != ST_IDLE);
      rx_valid   <= done_c;
      parity_err <= done_c & perr_q;
      frame_err  <= done_c & (ferr_q | ~rx_s);
      if (done_c) rx_data <= shreg_q;

      if (state_q == ST_IDLE || state_q == ST_BREAK) cnt_q <= '0;
      else cnt_q <= wrap_c ? '0 : cnt_q + CNT_W'(1);

      if (start_c) begin
        bit_idx_q  <= '0;
        stop_idx_q <= 1'b0;
        perr_q     <= 1'b0;
        ferr_q     <= 1'b0;
      end
      // LSB arrives first, so shift in from the top.
      if (shift_c) begin
        shreg_q   <= {rx_s, shreg_q[DATA_BITS-1:1]};
        bit_idx_q <= bit_idx_q + IDX_W'(1);
      end
      if (par_smp_c) perr_q <= (rx_s != par_exp_c);
      if (stop_smp_c && !rx_s) ferr_q <= 1'b1;
      if (stop_adv_c) stop_idx_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: five configurations driven by a frame generator,
// results checked against a scoreboard of expected frames and latencies.
module tb_uart_rx_param;

  localparam int NI = 5;
  // Per-instance configuration: data bits, parity mode, stop bits, cycles/bit.
  localparam int CF_NB  [NI] = '{8, 8, 8, 5, 8};
  localparam int CF_PAR [NI] = '{0, 2, 0, 0, 1};
  localparam int CF_NS  [NI] = '{1, 1, 1, 2, 1};
  localparam int CF_BC  [NI] = '{434, 16, 16, 16, 16};
  localparam int unsigned FAST_CLK = 1_843_200;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    longint     t0;
  } exp_t;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       pbit;
    logic       ep;
  } vec_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic [NI-1:0] rx_l;
  logic [NI-1:0] vld, perr, ferr, bsy;
  logic [7:0] d0, d1, d2, d4;
  logic [4:0] d3;
  logic [8:0] dat [NI];

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  logic [7:0] bytes [256];
  vec_t   vt [9];

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  uart_rx_param u_def (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_l[0]), .rx_data(d0),
    .rx_valid(vld[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .busy(bsy[0]));

  uart_rx_param #(.CLK_FREQ(FAST_CLK), .PARITY(2)) u_even (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_l[1]), .rx_data(d1),
    .rx_valid(vld[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .busy(bsy[1]));

  uart_rx_param #(.CLK_FREQ(FAST_CLK)) u_8n1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_l[2]), .rx_data(d2),
    .rx_valid(vld[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .busy(bsy[2]));

  uart_rx_param #(.CLK_FREQ(FAST_CLK), .DATA_BITS(5), .STOP_BITS(2)) u_5n2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_l[3]), .rx_data(d3),
    .rx_valid(vld[3]), .parity_err(perr[3]), .frame_err(ferr[3]), .busy(bsy[3]));

  uart_rx_param #(.CLK_FREQ(FAST_CLK), .PARITY(1)) u_odd (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_l[4]), .rx_data(d4),
    .rx_valid(vld[4]), .parity_err(perr[4]), .frame_err(ferr[4]), .busy(bsy[4]));

  always_comb begin
    dat[0] = {1'b0, d0};
    dat[1] = {1'b0, d1};
    dat[2] = {1'b0, d2};
    dat[3] = {4'b0, d3};
    dat[4] = {1'b0, d4};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame on line i; must be called right after a negedge.
  task automatic send(input int i, input logic [8:0] d, input logic pbit,
                      input logic stop_lvl, input logic ep, input logic ef);
    exp_t e;
    int   bc;
    bc     = CF_BC[i];
    e.inst = i;
    e.data = d;
    e.perr = ep;
    e.ferr = ef;
    e.t0   = cyc;
    sb.push_back(e);
    rx_l[i] = 1'b0;
    repeat (bc) @(negedge sys_clk);
    for (int b = 0; b < CF_NB[i]; b++) begin
      rx_l[i] = d[b];
      repeat (bc) @(negedge sys_clk);
    end
    if (CF_PAR[i] != 0) begin
      rx_l[i] = pbit;
      repeat (bc) @(negedge sys_clk);
    end
    for (int s = 0; s < CF_NS[i]; s++) begin
      rx_l[i] = (s == 0) ? stop_lvl : 1'b1;
      repeat (bc) @(negedge sys_clk);
    end
  endtask

  task automatic send_bytes(input int i, input int n);
    for (int k = 0; k < n; k++) send(i, {1'b0, bytes[k]}, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every rx_valid must match the oldest expected frame.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      for (int i = 0; i < NI; i++) begin
        if (vld[i]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: inst %0d got data %0h expected no frame", i, dat[i]);
          end else begin
            exp_t   e;
            longint lat, el;
            e = sb.pop_front();
            chk("valid_inst", 64'(i), 64'(e.inst));
            chk("rx_data", 64'(dat[i]), 64'(e.data));
            chk("parity_err", 64'(perr[i]), 64'(e.perr));
            chk("frame_err", 64'(ferr[i]), 64'(e.ferr));
            lat = cyc - e.t0;
            el  = 3 + longint'((CF_NB[e.inst] + ((CF_PAR[e.inst] != 0) ? 1 : 0) + CF_NS[e.inst])
                  * CF_BC[e.inst] + CF_BC[e.inst] / 2);
            checks++;
            if (lat > el + 1 || lat < el - 1) begin
              errors++;
              $display("FAIL latency: inst %0d got %0d expected %0d", i, lat, el);
            end
          end
        end else begin
          chk("err_outside_valid", 64'({perr[i], ferr[i]}), 64'd0);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 9'h055, 1'b0, 1'b0};
    vt[1] = '{1, 9'h0A7, 1'b1, 1'b0};
    vt[2] = '{1, 9'h0A7, 1'b0, 1'b1};
    vt[3] = '{1, 9'h000, 1'b0, 1'b0};
    vt[4] = '{1, 9'h0FF, 1'b1, 1'b1};
    vt[5] = '{4, 9'h000, 1'b1, 1'b0};
    vt[6] = '{4, 9'h001, 1'b1, 1'b1};
    vt[7] = '{4, 9'h080, 1'b0, 1'b0};
    vt[8] = '{2, 9'h05A, 1'b0, 1'b0};
    for (int k = 0; k < 256; k++) bytes[k] = 8'(k);

    sys_rst_n = 1'b0;
    rx_l      = '1;
    repeat (3) @(negedge sys_clk);
    chk("rst_valid", 64'(vld), 64'd0);
    chk("rst_busy", 64'(bsy), 64'd0);
    chk("rst_perr", 64'(perr), 64'd0);
    chk("rst_ferr", 64'(ferr), 64'd0);
    for (int i = 0; i < NI; i++) chk("rst_data", 64'(dat[i]), 64'd0);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    for (int k = 0; k < 9; k++)
      send(vt[k].inst, vt[k].data, vt[k].pbit, 1'b1, vt[k].ep, 1'b0);
    repeat (20) @(negedge sys_clk);
    chk("busy_after_table", 64'(bsy), 64'd0);

    // Short low glitch on an idle line is a false start.
    rx_l[0] = 1'b0;
    repeat (100) @(negedge sys_clk);
    chk("busy_during_glitch", 64'(bsy[0]), 64'd1);
    rx_l[0] = 1'b1;
    repeat (434) @(negedge sys_clk);
    chk("busy_after_glitch", 64'(bsy[0]), 64'd0);

    // Bad stop bit with the line held low (break), then recovery.
    send(2, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (19 * 16) @(negedge sys_clk);
    chk("busy_in_break", 64'(bsy[2]), 64'd1);
    rx_l[2] = 1'b1;
    repeat (6) @(negedge sys_clk);
    chk("busy_break_release", 64'(bsy[2]), 64'd0);
    repeat (16) @(negedge sys_clk);
    send(2, 9'h081, 1'b0, 1'b1, 1'b0, 1'b0);

    send_bytes(2, 256);
    send_bytes(3, 32);
    repeat (20) @(negedge sys_clk);

    // Reset during data bit 4; trailing bits stay high so no new edge appears.
    rx_l[2] = 1'b0;
    repeat (5 * 16) @(negedge sys_clk);
    rx_l[2] = 1'b1;
    repeat (8) @(negedge sys_clk);
    chk("busy_mid_frame", 64'(bsy[2]), 64'd1);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst_mid_busy", 64'(bsy), 64'd0);
    chk("rst_mid_valid", 64'(vld), 64'd0);
    chk("rst_mid_data", 64'(dat[2]), 64'd0);
    sys_rst_n = 1'b1;
    repeat (6 * 16) @(negedge sys_clk);
    chk("busy_after_abort", 64'(bsy[2]), 64'd0);
    send(2, 9'h012, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int w = 0; w < 2000 && sb.size() != 0; w++) @(negedge sys_clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
